// File: rtl/risc_cpu_sys.sv
// 8-bit accumulator CPU subsystem: core, 8K x 8 program ROM and address decode.
// Each two-byte instruction runs through a fixed eight-state sequence.
module risc_cpu_sys #(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 8,
  parameter logic [1:0]  RAM_BASE = 2'b11
) (
  input  logic          sys_clk,
  input  logic          rst,
  output logic          halt,
  output logic          rd,
  output logic          wr,
  output logic [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
  output logic          ram_sel,
  output logic          rom_sel,
  output logic [2:0]    opcode,
  output logic          fetch,
  output logic [AW-1:0] ir_addr,
  output logic [AW-1:0] pc_addr
);

  localparam int unsigned IW = 2 * DW;

  typedef enum logic [3:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    HALTED = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } op_e;

  // Program store; contents are loaded by the simulation environment.
  logic [DW-1:0] rom [0:(2**AW)-1];

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          halt_q, halt_d;

  op_e  op_s;
  logic zero_s;
  logic mem_rd_op_s;
  logic is_sto_s;
  logic cpu_drv_s;
  logic rom_drv_s;

  function automatic logic [DW-1:0] alu(input op_e op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    case (op)
      OP_ADD:  alu = a + b;
      OP_AND:  alu = a & b;
      OP_XOR:  alu = a ^ b;
      OP_LDA:  alu = b;
      default: alu = a;
    endcase
  endfunction

  assign op_s        = op_e'(ir_q[IW-1 -: 3]);
  assign zero_s      = (acc_q == {DW{1'b0}});
  assign mem_rd_op_s = (op_s == OP_ADD) || (op_s == OP_AND) ||
                       (op_s == OP_XOR) || (op_s == OP_LDA);
  assign is_sto_s    = (op_s == OP_STO);

  assign opcode  = ir_q[IW-1 -: 3];
  assign ir_addr = ir_q[AW-1:0];
  assign pc_addr = pc_q;
  assign halt    = halt_q;

  // State register and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S0;
      pc_q    <= {AW{1'b0}};
      acc_q   <= {DW{1'b0}};
      ir_q    <= {IW{1'b0}};
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      halt_q  <= halt_d;
    end
  end

  // Next-state sequencing and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    halt_d  = halt_q;
    case (state_q)
      S0: begin
        ir_d[IW-1:DW] = data;
        pc_d          = pc_q + AW'(2'd1);
        state_d       = S1;
      end
      S1: begin
        ir_d[DW-1:0] = data;
        pc_d         = pc_q + AW'(2'd1);
        state_d      = S2;
      end
      S2: begin
        if (op_s == OP_HLT) begin
          halt_d  = 1'b1;
          state_d = HALTED;
        end else begin
          state_d = S3;
        end
      end
      S3: state_d = S4;
      S4: state_d = S5;
      S5: begin
        state_d = S6;
        if (mem_rd_op_s) begin
          acc_d = alu(op_s, acc_q, data);
        end else if (op_s == OP_JMP) begin
          pc_d = ir_q[AW-1:0];
        end else if ((op_s == OP_SKZ) && zero_s) begin
          pc_d = pc_q + AW'(2'd2);
        end else begin
          acc_d = acc_q;
        end
      end
      S6:      state_d = S7;
      S7:      state_d = S0;
      HALTED:  state_d = HALTED;
      default: state_d = S0;
    endcase
  end

  // Bus strobes and drive enables decoded from the current state.
  always_comb begin
    fetch     = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    cpu_drv_s = 1'b0;
    case (state_q)
      S0, S1: begin
        fetch = 1'b1;
        rd    = 1'b1;
      end
      S2, S3: fetch = 1'b1;
      S4: begin
        rd        = mem_rd_op_s;
        cpu_drv_s = is_sto_s;
      end
      S5: begin
        rd        = mem_rd_op_s;
        wr        = is_sto_s;
        cpu_drv_s = is_sto_s;
      end
      S6:      cpu_drv_s = is_sto_s;
      default: fetch = 1'b0;
    endcase
  end

  assign addr    = fetch ? pc_q : ir_q[AW-1:0];
  assign ram_sel = (addr[AW-1 -: 2] == RAM_BASE);
  assign rom_sel = ~ram_sel;

  // Only one of ROM and CPU can own the bus: ROM needs rd, CPU only drives with rd low.
  assign rom_drv_s = rd & rom_sel;
  assign data = rom_drv_s ? rom[addr] : (cpu_drv_s ? acc_q : {DW{1'bz}});

endmodule

// File: tb/tb_risc_cpu_sys.sv
// Directed bench for risc_cpu_sys with a 2K x 8 SRAM model on the shared bus.
module tb_risc_cpu_sys;

  logic        sys_clk;
  logic        rst;
  logic        halt;
  logic        rd;
  logic        wr;
  logic [12:0] addr;
  wire  [7:0]  data;
  logic        ram_sel;
  logic        rom_sel;
  logic [2:0]  opcode;
  logic        fetch;
  logic [12:0] ir_addr;
  logic [12:0] pc_addr;

  logic [7:0]  ram [0:2047];
  logic        pre_we;
  logic [10:0] pre_a;
  logic [7:0]  pre_v;

  int n_checks;
  int n_fail;
  int cyc_now;

  risc_cpu_sys dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .halt    (halt),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .data    (data),
    .ram_sel (ram_sel),
    .rom_sel (rom_sel),
    .opcode  (opcode),
    .fetch   (fetch),
    .ir_addr (ir_addr),
    .pc_addr (pc_addr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // External SRAM: answers reads on the bus, captures writes at the clock edge.
  assign data = (rd && ram_sel) ? ram[addr[10:0]] : 8'hzz;

  always @(posedge sys_clk) begin
    if (pre_we) ram[pre_a] <= pre_v;
    else if (wr && ram_sel) ram[addr[10:0]] <= data;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ram_put(input logic [10:0] a, input logic [7:0] v);
    pre_we = 1'b1;
    pre_a  = a;
    pre_v  = v;
    @(posedge sys_clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic start_prog();
    rst = 1'b1;
    for (int i = 0; i < 8192; i++) dut.rom[i] = 8'h00;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge sys_clk);
    #1 rst = 1'b0;
    @(negedge sys_clk);
    cyc_now = 0;
  endtask

  task automatic goto_cyc(input int k);
    repeat (k - cyc_now) @(negedge sys_clk);
    cyc_now = k;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc_now  = 0;
    pre_we   = 1'b0;
    pre_a    = 11'd0;
    pre_v    = 8'd0;
    rst      = 1'b1;
    @(negedge sys_clk);

    // LDA 0x1800 / ADD 0x1801 / STO 0x1802 / HLT
    start_prog();
    dut.rom[0] = 8'hB8; dut.rom[1] = 8'h00;
    dut.rom[2] = 8'h58; dut.rom[3] = 8'h01;
    dut.rom[4] = 8'hD8; dut.rom[5] = 8'h02;
    ram_put(11'd0, 8'h7F);
    ram_put(11'd1, 8'h82);
    ram_put(11'd2, 8'hEE);
    release_reset();
    check("rst_pc", pc_addr, 16'h0000);
    check("rst_halt", halt, 16'h0);
    check("rst_wr", wr, 16'h0);
    check("rst_fetch", fetch, 16'h1);
    check("rst_addr", addr, 16'h0000);
    check("rst_rd", rd, 16'h1);
    check("rst_romsel", rom_sel, 16'h1);
    goto_cyc(20);
    check("sto_s4_data", data, 16'h0001);
    check("sto_s4_rdwr", {rd, wr}, 16'h0);
    goto_cyc(21);
    check("sto_s5_wr", wr, 16'h1);
    check("sto_s5_addr", addr, 16'h1802);
    check("sto_s5_ramsel", ram_sel, 16'h1);
    goto_cyc(26);
    check("hlt_s2_halt", halt, 16'h0);
    goto_cyc(27);
    check("hlt_halt", halt, 16'h1);
    check("hlt_pc", pc_addr, 16'h0008);
    check("add_wrap_ram2", ram[2], 16'h0001);
    goto_cyc(35);
    check("halted_pc", pc_addr, 16'h0008);
    check("halted_strobes", {fetch, rd, wr}, 16'h0);

    // LDA F0 / AND 3C / XOR 30 / SKZ (taken) / STO skipped / STO / HLT
    start_prog();
    dut.rom[0]  = 8'hB8; dut.rom[1]  = 8'h00;
    dut.rom[2]  = 8'h78; dut.rom[3]  = 8'h01;
    dut.rom[4]  = 8'h98; dut.rom[5]  = 8'h02;
    dut.rom[6]  = 8'h20; dut.rom[7]  = 8'h00;
    dut.rom[8]  = 8'hD8; dut.rom[9]  = 8'h03;
    dut.rom[10] = 8'hD8; dut.rom[11] = 8'h04;
    ram_put(11'd0, 8'hF0);
    ram_put(11'd1, 8'h3C);
    ram_put(11'd2, 8'h30);
    ram_put(11'd3, 8'hAA);
    ram_put(11'd4, 8'h55);
    release_reset();
    goto_cyc(32);
    check("skz_taken_pc", pc_addr, 16'h000A);
    goto_cyc(36);
    check("xor_zero_data", data, 16'h0000);
    goto_cyc(43);
    check("skz_taken_halt", halt, 16'h1);
    check("skz_taken_pcfin", pc_addr, 16'h000E);
    check("skz_skipped_ram3", ram[3], 16'h00AA);
    check("sto_after_ram4", ram[4], 16'h0000);

    // LDA 01 / SKZ (not taken) / STO 0x1801 / HLT
    start_prog();
    dut.rom[0] = 8'hB8; dut.rom[1] = 8'h00;
    dut.rom[2] = 8'h20; dut.rom[3] = 8'h00;
    dut.rom[4] = 8'hD8; dut.rom[5] = 8'h01;
    ram_put(11'd0, 8'h01);
    ram_put(11'd1, 8'h00);
    release_reset();
    goto_cyc(16);
    check("skz_fall_pc", pc_addr, 16'h0004);
    goto_cyc(27);
    check("skz_fall_halt", halt, 16'h1);
    check("skz_fall_pcfin", pc_addr, 16'h0008);
    check("skz_fall_ram1", ram[1], 16'h0001);

    // JMP 0x0010; a HLT at 0x0010
    start_prog();
    dut.rom[0] = 8'hE0; dut.rom[1] = 8'h10;
    dut.rom[2] = 8'hB8; dut.rom[3] = 8'h00;
    release_reset();
    goto_cyc(2);
    check("jmp_op_s2", opcode, 16'h7);
    goto_cyc(5);
    check("jmp_iraddr", ir_addr, 16'h0010);
    goto_cyc(7);
    check("jmp_op_s7", opcode, 16'h7);
    goto_cyc(8);
    check("jmp_fetch_addr", addr, 16'h0010);
    goto_cyc(11);
    check("jmp_halt", halt, 16'h1);
    check("jmp_pcfin", pc_addr, 16'h0012);

    // Decode edge: run through 0x17FE..0x1801, fetching JMP 0x0020 from SRAM
    start_prog();
    dut.rom[0]      = 8'hF7; dut.rom[1]      = 8'hFE;
    dut.rom[13'h17FE] = 8'h60; dut.rom[13'h17FF] = 8'h00;
    ram_put(11'd0, 8'hE0);
    ram_put(11'd1, 8'h20);
    release_reset();
    goto_cyc(9);
    check("dec_17ff_addr", addr, 16'h17FF);
    check("dec_17ff_sel", {rom_sel, ram_sel}, 16'h2);
    goto_cyc(16);
    check("dec_1800_addr", addr, 16'h1800);
    check("dec_1800_sel", {rom_sel, ram_sel}, 16'h1);
    check("dec_1800_data", data, 16'h00E0);
    goto_cyc(24);
    check("ramfetch_jmp_pc", pc_addr, 16'h0020);
    goto_cyc(27);
    check("ramfetch_halt", halt, 16'h1);

    // SKZ at 0x1FFE with acc=0: pc wraps and skips to 0x0002
    start_prog();
    dut.rom[0] = 8'hFF; dut.rom[1] = 8'hFE;
    ram_put(11'h7FE, 8'h20);
    ram_put(11'h7FF, 8'h00);
    release_reset();
    goto_cyc(10);
    check("wrap_pc", pc_addr, 16'h0000);
    goto_cyc(16);
    check("wrap_skz_pc", pc_addr, 16'h0002);
    goto_cyc(19);
    check("wrap_halt", halt, 16'h1);

    // Reset asserted during STO S5
    start_prog();
    dut.rom[0] = 8'hB8; dut.rom[1] = 8'h00;
    dut.rom[2] = 8'hD8; dut.rom[3] = 8'h01;
    ram_put(11'd0, 8'h5A);
    release_reset();
    goto_cyc(13);
    check("rststo_s5_wr", wr, 16'h1);
    check("rststo_s5_data", data, 16'h005A);
    rst = 1'b1;
    goto_cyc(14);
    check("rststo_wr", wr, 16'h0);
    check("rststo_pc", pc_addr, 16'h0000);
    check("rststo_bus", data, 16'h00B8);
    check("rststo_fetch", fetch, 16'h1);
    goto_cyc(15);
    check("rststo_hold_wr", wr, 16'h0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
